conv_frame_sequencer: RTL

Frame-level controller that feeds one 3-channel input image into the stride-2 3x3 convolution stage (3-input-channel, 32-output-channel layer) and tracks its outputs. Accepts pixels from an upstream ready/valid stream, drives the conv stage's per-channel valid/pixel inputs, counts input raster position and output pixels, and signals frame completion or a drain timeout to the layer scheduler above it.

---
 rtl/conv_ctrl_pkg.sv | 18 +
 rtl/raster_counter.sv | 55 +++++
 rtl/conv_frame_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared constants and types for the conv layer sequencers.
package conv_ctrl_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } seq_state_e;

  function automatic int unsigned out_pix(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row raster position counter; holds at the last position instead of wrapping.
module raster_counter
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned COLS  = 299,
  parameter int unsigned ROWS  = 299
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] col_o,
  output logic [CNT_W-1:0] row_o,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COLS - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROWS - 1);

  logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
  logic             col_wrap;

  assign col_wrap = (col_q == COL_LAST);
  assign last_o   = col_wrap && (row_q == ROW_LAST);
  assign col_o    = col_q;
  assign row_o    = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i && !last_o) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame controller: streams one RGB frame into the stride-2 conv stage and tracks its outputs.
module conv_frame_sequencer
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned IMG_W         = 299,
  parameter int unsigned IMG_H         = 299,
  parameter int unsigned OUT_W         = 149,
  parameter int unsigned OUT_H         = 149,
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter int unsigned DRAIN_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_pxl_1,
  input  logic [DATA_WIDTH-1:0] s_pxl_2,
  input  logic [DATA_WIDTH-1:0] s_pxl_3,
  output logic                  conv_valid_in_1,
  output logic                  conv_valid_in_2,
  output logic                  conv_valid_in_3,
  output logic [DATA_WIDTH-1:0] conv_pxl_in_1,
  output logic [DATA_WIDTH-1:0] conv_pxl_in_2,
  output logic [DATA_WIDTH-1:0] conv_pxl_in_3,
  input  logic                  conv_valid_out,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_timeout,
  output logic                  err_overflow,
  output logic [CNT_W-1:0]      in_col,
  output logic [CNT_W-1:0]      in_row,
  output logic [CNT_W-1:0]      out_count
);

  localparam int unsigned      IDLE_W    = $clog2(DRAIN_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] OUT_PIX   = CNT_W'(out_pix(OUT_W, OUT_H));
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_TIMEOUT - 1);

  seq_state_e            state_q;
  logic [IDLE_W-1:0]     idle_q, idle_d;
  logic [CNT_W-1:0]      out_count_q, out_count_d;
  logic [DATA_WIDTH-1:0] pxl1_q, pxl2_q, pxl3_q;
  logic                  valid_q, frame_done_q, err_to_q, err_ovf_q;
  logic                  start_ok, accept, active, out_full, out_inc, ovf_evt, last_pix;

  assign s_ready  = (state_q == ST_LOAD);
  assign busy     = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign active   = busy;
  assign accept   = s_ready && s_valid;
  assign start_ok = start && !active;
  assign out_full = (out_count_q == OUT_PIX);
  assign out_inc  = conv_valid_out && active && !out_full;
  assign ovf_evt  = conv_valid_out && (!active || out_full);

  raster_counter #(
    .CNT_W (CNT_W),
    .COLS  (IMG_W),
    .ROWS  (IMG_H)
  ) u_raster (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (abort || start_ok),
    .en_i   (accept && !abort),
    .col_o  (in_col),
    .row_o  (in_row),
    .last_o (last_pix)
  );

  always_comb begin
    out_count_d = out_count_q + CNT_W'(out_inc);
    if (abort || start_ok) out_count_d = '0;
    idle_d = '0;
    if (state_q == ST_DRAIN && !abort && !conv_valid_out) idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      idle_q       <= '0;
      out_count_q  <= '0;
      pxl1_q       <= '0;
      pxl2_q       <= '0;
      pxl3_q       <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      err_to_q     <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      out_count_q  <= out_count_d;
      idle_q       <= idle_d;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (ovf_evt) err_ovf_q <= 1'b1;
      if (abort) begin
        state_q <= ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
              state_q   <= ST_LOAD;
              err_to_q  <= 1'b0;
              // an overflow on the very start edge still registers
              err_ovf_q <= ovf_evt;
            end else if (state_q == ST_DONE) begin
              state_q <= ST_IDLE;
            end
          end
          ST_LOAD: begin
            if (accept) begin
              valid_q <= 1'b1;
              pxl1_q  <= s_pxl_1;
              pxl2_q  <= s_pxl_2;
              pxl3_q  <= s_pxl_3;
              if (last_pix) state_q <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (out_count_d == OUT_PIX) begin
              state_q      <= ST_DONE;
              frame_done_q <= 1'b1;
            end else if (!conv_valid_out && idle_q == IDLE_LAST) begin
              state_q  <= ST_ERR;
              err_to_q <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign conv_valid_in_1 = valid_q;
  assign conv_valid_in_2 = valid_q;
  assign conv_valid_in_3 = valid_q;
  assign conv_pxl_in_1   = pxl1_q;
  assign conv_pxl_in_2   = pxl2_q;
  assign conv_pxl_in_3   = pxl3_q;
  assign frame_done      = frame_done_q;
  assign err_timeout     = err_to_q;
  assign err_overflow    = err_ovf_q;
  assign out_count       = out_count_q;

endmodule
